// File: rtl/mem_requester.sv
`default_nettype none
// ============================================================================
// Module      : mem_requester
// Description : Request-side master for a 16x8 memory port. Accepts single-
//               beat read/write requests over valid/ready, sequences the
//               memory strobes, waits a fixed read latency, and returns read
//               data on a valid/ready response channel. One transaction is
//               outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_requester #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              wr_done,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter preload: mem_read stays high for RD_LAT cycles, the last of
    // which is the capture cycle where the counter reads zero.
    localparam logic [3:0] c_lat_init = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [3:0]          cnt_q,       cnt_d;
    logic                mem_write_q, mem_write_d;
    logic                mem_read_q,  mem_read_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic                wr_done_q,   wr_done_d;

    // Next-state and registered-output computation; everything holds by default.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_write_d = mem_write_q;
        mem_read_d  = mem_read_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        wr_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mem_addr_d = req_addr;
                    if (req_we) begin
                        mem_wdata_d = req_wdata;
                        mem_write_d = 1'b1;
                        state_d     = ST_WR;
                    end else begin
                        mem_read_d = 1'b1;
                        cnt_d      = c_lat_init;
                        state_d    = ST_RD;
                    end
                end
            end
            ST_WR: begin
                mem_write_d = 1'b0;
                wr_done_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_RD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d  = mem_rdata;
                    mem_read_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                mem_write_d = 1'b0;
                mem_read_d  = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign wr_done   = wr_done_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_requester
// Description : Directed plus randomized bench for mem_requester with a
//               latency-accurate memory model and an array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_requester;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              wr_done;
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Expected memory contents and last write data, updated as writes complete.
    logic [DATA_W-1:0] ref_mem [16];
    logic [DATA_W-1:0] last_wdata;

    // Memory model: storage plus a read path that is only valid RD_LAT cycles
    // after mem_read first rises.
    logic [DATA_W-1:0] mem_arr [16];
    int                rd_age;

    always #5 clk = ~clk;

    mem_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .wr_done   (wr_done),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr] <= mem_wdata;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rd_age <= 0;
        else     rd_age <= mem_read ? rd_age + 1 : 0;
    end

    assign mem_rdata = (mem_read && rd_age == RD_LAT - 1) ? mem_arr[mem_addr] : 8'hEE;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("strobe_exclusive", 32'(mem_write & mem_read), 32'd0);
    endtask

    task automatic check_idle_outputs_zero();
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_read",  32'(mem_read),  32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_wr_done",   32'(wr_done),   32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        check("wr_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_wdata = ~d;
        check("wr_mem_write", 32'(mem_write), 32'd1);
        check("wr_mem_addr",  32'(mem_addr),  32'(a));
        check("wr_mem_wdata", 32'(mem_wdata), 32'(d));
        check("wr_busy",      32'(req_ready), 32'd0);
        check("wr_done_early", 32'(wr_done),  32'd0);
        tick();
        check("wr_strobe_off", 32'(mem_write), 32'd0);
        check("wr_done",       32'(wr_done),   32'd1);
        check("wr_idle",       32'(req_ready), 32'd1);
        ref_mem[a] = d;
        last_wdata = d;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int hold);
        logic [DATA_W-1:0] exp_d;
        exp_d = ref_mem[a];
        check("rd_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'h00;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            check("rd_mem_read",  32'(mem_read),  32'd1);
            check("rd_no_rsp",    32'(rsp_valid), 32'd0);
            check("rd_mem_addr",  32'(mem_addr),  32'(a));
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rsp_ready = 1'b0;
        check("rd_rsp_valid",  32'(rsp_valid), 32'd1);
        check("rd_rsp_data",   32'(rsp_data),  32'(exp_d));
        check("rd_read_off",   32'(mem_read),  32'd0);
        check("rd_wdata_keep", 32'(mem_wdata), 32'(last_wdata));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_we = 1'b1;
            tick();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data",  32'(rsp_data),  32'(exp_d));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_no_write",  32'(mem_write), 32'd0);
        end
        // A request presented in the release cycle must not be taken.
        req_valid = 1'b1; req_we = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rel_req_ready", 32'(req_ready), 32'd1);
        check("rel_no_write",  32'(mem_write), 32'd0);
        check("rel_addr_keep", 32'(mem_addr),  32'(a));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            mem_arr[i] = '0;
        end
        last_wdata = '0;

        // Power-on reset.
        #2;
        check_idle_outputs_zero();
        #20;
        rst = 1'b0;
        tick();
        check("por_idle", 32'(req_ready), 32'd1);

        // Write then overwrite address 3, read back.
        do_write(4'h3, 8'hA5);
        tick();
        check("wr_addr_keep",  32'(mem_addr),  32'h3);
        check("wr_wdata_keep", 32'(mem_wdata), 32'hA5);
        check("wr_done_pulse", 32'(wr_done),   32'd0);
        do_write(4'h3, 8'h5A);
        do_read(4'h3, 0);

        // Backpressure for 5 cycles.
        do_read(4'h3, 5);

        // Async reset during a write: strobe drops at once, no wr_done follows.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h9; req_wdata = 8'h77;
        tick();
        req_valid = 1'b0;
        check("pre_rst_write", 32'(mem_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs_zero();
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check("rst_wr_no_done", 32'(wr_done),   32'd0);
        check("rst_wr_idle",    32'(req_ready), 32'd1);
        last_wdata = '0;

        // Back-to-back writes over the full address range, then reads.
        for (int a = 0; a < 16; a++) do_write(4'(a), 8'($urandom));
        for (int a = 0; a < 16; a++) do_read(4'(a), int'($urandom_range(0, 2)));

        // Async reset during a read: mem_read drops, no response appears.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h7;
        tick();
        req_valid = 1'b0;
        check("pre_rst_read", 32'(mem_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs_zero();
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < RD_LAT + 2; i++) begin
            tick();
            check("rst_rd_no_rsp",  32'(rsp_valid), 32'd0);
            check("rst_rd_no_read", 32'(mem_read),  32'd0);
        end
        last_wdata = '0;
        do_read(4'h7, 1);

        // Randomized mix of reads and writes.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(4'($urandom), 8'($urandom));
            else
                do_read(4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
